paddle_ctrl: RTL and testbench
==============================

// Module: paddle_ctrl
// PURPOSE
//   Upstream stage of the ball logic: turns four raw push-buttons into the two
//   paddle positions (paddle_y_l, paddle_y_r) the ball uses for collision.
//   Synchronises and debounces each button. Moves each paddle once per frame
//   tick, clamped to the screen. Also produces the paddle pixel mask and colour
//   for the VGA mixer.
// PARAMETERS
//   DEB_CYCLES   250000  clk cycles a changed button level must stay stable (5 ms @ 50 MHz)
//   PADDLE_H     50      paddle height, px (must match the ball's collision window)
//   PADDLE_W     10      paddle width, px
//   PADDLE_X_L   20      left paddle left edge, px
//   PADDLE_X_R   600     right paddle left edge, px
//   PADDLE_STEP  4       px moved per refr_tick
//   SCREEN_H     480     visible lines
//   Y_START      215     paddle top edge after reset
//   PADDLE_COLOR 12'hFFF paddle RGB444
// PORTS
//   clk          in   1   system clock
//   rstn         in   1   async active-low reset
//   refr_tick    in   1   one-cycle pulse per frame (same pulse the ball uses)
//   hold         in   1   1 = freeze both paddles (serve/pause)
//   btn_up_l     in   1   raw, asynchronous, active-high
//   btn_dn_l     in   1   raw, asynchronous, active-high
//   btn_up_r     in   1   raw, asynchronous, active-high
//   btn_dn_r     in   1   raw, asynchronous, active-high
//   pixel_x      in   10  current VGA column
//   pixel_y      in   10  current VGA row
//   paddle_y_l   out  10  left paddle top edge (registered)
//   paddle_y_r   out  10  right paddle top edge (registered)
//   paddle_on    out  1   current pixel lies inside either paddle (combinational)
//   paddle_rgb   out  12  PADDLE_COLOR (constant)
// BEHAVIOUR
//   Reset (async, rstn=0):
//     - paddle_y_l = paddle_y_r = Y_START.
//     - all sync flops, debounced levels and counters = 0.
//   Sync: each button passes through a 2-flop synchroniser.
//   Debounce (per button, 2-state FSM):
//     STABLE: cnt=0. sync != deb -> CHANGING.
//     CHANGING: cnt++ each cycle while sync != deb.
//       sync == deb -> STABLE, cnt=0.
//       cnt reaches DEB_CYCLES-1 -> deb <= sync, STABLE.
//     Clean edge -> deb changes exactly 2+DEB_CYCLES clk later.
//     Any pulse shorter than DEB_CYCLES is ignored.
//     Counter width = $clog2(DEB_CYCLES)+1.
//   Move (per paddle, only on refr_tick=1 and hold=0; otherwise y holds):
//     - up only: y <= (y < PADDLE_STEP) ? 0 : y - PADDLE_STEP.
//     - dn only: y <= (y > SCREEN_H-PADDLE_H-PADDLE_STEP) ? SCREEN_H-PADDLE_H : y + PADDLE_STEP.
//     - both or neither: hold.
//     - no underflow/overflow: y stays in [0, SCREEN_H-PADDLE_H] at all times.
//   Left and right paddles are fully independent.
//   Latency: deb change -> y updates on the next refr_tick (registered, 1 clk).
//   paddle_on = (PADDLE_X_L <= px < PADDLE_X_L+PADDLE_W && y_l <= py < y_l+PADDLE_H)
//            || (same for PADDLE_X_R / y_r). Compare in 11 bits.
//   Reset mid-debounce or mid-move: everything returns to reset values immediately.
// TESTING  (sim with DEB_CYCLES=4, refr_tick every 20 clk)
//   1. Release rstn -> y_l=y_r=215; pixel (0,0) gives paddle_on=0; no movement for 10 ticks.
//   2. Hold btn_up_l -> deb high 6 clk after press; 5 further ticks -> y_l=195, y_r=215.
//   3. btn_dn_r pulsed 3 clk (< DEB_CYCLES) -> deb stays 0, y_r stays 215.
//   4. Hold btn_dn_r 100 ticks -> y_r saturates at 430, never exceeds it.
//      Force y_l=2, hold btn_up_l -> 0, then stays 0.
//   5. up+dn both held on left -> y_l unchanged.
//      hold=1 with btn_up_r -> y_r unchanged; release hold -> moves 4 per tick.
//   6. y_l=y_r=215: (20,215)->1, (29,264)->1, (30,215)->0, (600,264)->1, (600,265)->0.
//      rstn pulse while moving -> y=215 within the same cycle.

Source files
------------

// File: rtl/paddle_ctrl_if.sv
// Bundle between the paddle controller and its neighbours: frame strobe, buttons,
// VGA pixel coordinates, paddle positions/pixel mask, plus debounce debug taps.
interface paddle_ctrl_if;
    // refr_tick is a one-cycle strobe with no handshake; every other signal is a level.
    logic       refr_tick;
    logic       hold;
    logic       btn_up_l;
    logic       btn_dn_l;
    logic       btn_up_r;
    logic       btn_dn_r;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [9:0] paddle_y_l;
    logic [9:0] paddle_y_r;
    logic       paddle_on;
    logic [11:0] paddle_rgb;
    // Bit order for both debug buses: {dn_r, up_r, dn_l, up_l}.
    logic [3:0] dbg_deb_lvl;
    logic [3:0] dbg_deb_busy;

    modport master (
        output refr_tick, hold, btn_up_l, btn_dn_l, btn_up_r, btn_dn_r, pixel_x, pixel_y,
        input  paddle_y_l, paddle_y_r, paddle_on, paddle_rgb, dbg_deb_lvl, dbg_deb_busy
    );

    modport slave (
        input  refr_tick, hold, btn_up_l, btn_dn_l, btn_up_r, btn_dn_r, pixel_x, pixel_y,
        output paddle_y_l, paddle_y_r, paddle_on, paddle_rgb, dbg_deb_lvl, dbg_deb_busy
    );
endinterface

// File: rtl/paddle_ctrl.sv
// Button synchronise/debounce, per-frame paddle movement with screen clamping,
// and the paddle pixel mask for the VGA mixer.
module paddle_ctrl #(
    parameter int          DEB_CYCLES   = 250000,
    parameter int          PADDLE_H     = 50,
    parameter int          PADDLE_W     = 10,
    parameter int          PADDLE_X_L   = 20,
    parameter int          PADDLE_X_R   = 600,
    parameter int          PADDLE_STEP  = 4,
    parameter int          SCREEN_H     = 480,
    parameter int          Y_START      = 215,
    parameter logic [11:0] PADDLE_COLOR = 12'hFFF
) (
    input logic          clk,
    input logic          rstn,
    paddle_ctrl_if.slave bus
);

    localparam int             CW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [9:0]     Y_INIT   = 10'(Y_START);
    localparam logic [9:0]     Y_MAX    = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0]     Y_DN_LIM = 10'(SCREEN_H - PADDLE_H - PADDLE_STEP);
    localparam logic [9:0]     STEP     = 10'(PADDLE_STEP);
    localparam logic [10:0]    XL_LO    = 11'(PADDLE_X_L);
    localparam logic [10:0]    XL_HI    = 11'(PADDLE_X_L + PADDLE_W);
    localparam logic [10:0]    XR_LO    = 11'(PADDLE_X_R);
    localparam logic [10:0]    XR_HI    = 11'(PADDLE_X_R + PADDLE_W);
    localparam logic [10:0]    H11      = 11'(PADDLE_H);

    typedef enum logic {ST_STABLE, ST_CHANGING} deb_state_t;

    logic [3:0]    w_raw;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_deb;
    logic [3:0]    w_deb_nxt;
    deb_state_t    r_state     [4];
    deb_state_t    w_state_nxt [4];
    logic [CW-1:0] r_cnt       [4];
    logic [CW-1:0] w_cnt_nxt   [4];
    logic [9:0]    r_y_l;
    logic [9:0]    r_y_r;

    assign w_raw = {bus.btn_dn_r, bus.btn_up_r, bus.btn_dn_l, bus.btn_up_l};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb   <= w_deb_nxt;
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // The commit fires on the cycle whose incremented count would reach DEB_CYCLES-1,
    // so a new level must be seen for exactly DEB_CYCLES consecutive cycles.
    always_comb begin
        w_deb_nxt = r_deb;
        for (int i = 0; i < 4; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = '0;
            case (r_state[i])
                ST_STABLE: begin
                    if (r_sync2[i] != r_deb[i]) w_state_nxt[i] = ST_CHANGING;
                end
                ST_CHANGING: begin
                    if (r_sync2[i] == r_deb[i]) begin
                        w_state_nxt[i] = ST_STABLE;
                    end else if (r_cnt[i] + CNT_ONE == CNT_LAST) begin
                        w_deb_nxt[i]   = r_sync2[i];
                        w_state_nxt[i] = ST_STABLE;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                    end
                end
                default: w_state_nxt[i] = ST_STABLE;
            endcase
        end
    end

    function automatic logic [9:0] f_move(input logic [9:0] y, input logic up, input logic dn);
        logic [9:0] res;
        res = y;
        if (up && !dn)      res = (y < STEP) ? 10'd0 : y - STEP;
        else if (dn && !up) res = (y > Y_DN_LIM) ? Y_MAX : y + STEP;
        return res;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_y_l <= Y_INIT;
            r_y_r <= Y_INIT;
        end else if (bus.refr_tick && !bus.hold) begin
            r_y_l <= f_move(r_y_l, r_deb[0], r_deb[1]);
            r_y_r <= f_move(r_y_r, r_deb[2], r_deb[3]);
        end
    end

    logic [10:0] w_px;
    logic [10:0] w_py;
    logic [10:0] w_yl;
    logic [10:0] w_yr;
    logic        w_on_l;
    logic        w_on_r;

    // Widened to 11 bits so y + PADDLE_H cannot wrap near the bottom edge.
    assign w_px   = {1'b0, bus.pixel_x};
    assign w_py   = {1'b0, bus.pixel_y};
    assign w_yl   = {1'b0, r_y_l};
    assign w_yr   = {1'b0, r_y_r};
    assign w_on_l = (w_px >= XL_LO) && (w_px < XL_HI) && (w_py >= w_yl) && (w_py < w_yl + H11);
    assign w_on_r = (w_px >= XR_LO) && (w_px < XR_HI) && (w_py >= w_yr) && (w_py < w_yr + H11);

    assign bus.paddle_on  = w_on_l || w_on_r;
    assign bus.paddle_y_l = r_y_l;
    assign bus.paddle_y_r = r_y_r;
    assign bus.paddle_rgb = PADDLE_COLOR;

    always_comb begin
        bus.dbg_deb_lvl  = r_deb;
        bus.dbg_deb_busy = '0;
        for (int i = 0; i < 4; i++) bus.dbg_deb_busy[i] = (r_state[i] == ST_CHANGING);
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: directed scenarios plus random button traffic
// compared every cycle against a run-length/clamp reference model.
module tb_paddle_ctrl;

    localparam int DEB      = 4;
    localparam int TICK_PER = 20;
    localparam int Y_START  = 215;
    localparam int Y_MAX    = 430;
    localparam int STEP     = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   rand_pix = 1'b1;

    paddle_ctrl_if bus ();

    paddle_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounced level flips once the synchronised level has disagreed with it
    // for DEB consecutive clocks; positions are clamped arithmetic.
    logic [3:0]  m_s1, m_s2, m_deb;
    int          m_run [4];
    int          m_yl, m_yr;
    logic [23:0] exp_q [$];

    function automatic int model_move(input int y, input logic up, input logic dn);
        if (up && !dn) return (y - STEP < 0) ? 0 : y - STEP;
        if (dn && !up) return (y + STEP > Y_MAX) ? Y_MAX : y + STEP;
        return y;
    endfunction

    function automatic logic model_on(input int px, input int py, input int yl, input int yr);
        logic in_l, in_r;
        in_l = (px >= 20)  && (px < 30)  && (py >= yl) && (py < yl + 50);
        in_r = (px >= 600) && (px < 610) && (py >= yr) && (py < yr + 50);
        return in_l || in_r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_yl = Y_START; m_yr = Y_START;
            exp_q.delete();
        end else begin
            if (bus.refr_tick && !bus.hold) begin
                m_yl = model_move(m_yl, m_deb[0], m_deb[1]);
                m_yr = model_move(m_yr, m_deb[2], m_deb[3]);
            end
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_deb[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {bus.btn_dn_r, bus.btn_up_r, bus.btn_dn_l, bus.btn_up_l};
            exp_q.push_back({m_deb, 10'(m_yr), 10'(m_yl)});
        end
    end

    // Scoreboard compare, then drive pixel and frame tick for the next cycle.
    always @(negedge clk) begin
        logic [23:0] e;
        if (rstn && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("y_l", bus.paddle_y_l, e[9:0]);
            check("y_r", bus.paddle_y_r, e[19:10]);
            check("deb", bus.dbg_deb_lvl, e[23:20]);
            check("on", bus.paddle_on,
                  model_on(int'(bus.pixel_x), int'(bus.pixel_y), int'(e[9:0]), int'(e[19:10])));
        end
        cyc++;
        bus.refr_tick = (cyc % TICK_PER == TICK_PER - 1);
        if (rand_pix) begin
            bus.pixel_x = 10'($urandom_range(0, 639));
            bus.pixel_y = 10'($urandom_range(0, 479));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            while (!bus.refr_tick) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic wait_deb(input int idx, input logic val, input string tag);
        int n = 0;
        while (bus.dbg_deb_lvl[idx] !== val && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.dbg_deb_lvl[idx], val);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        wait_clks(3);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_y_l", bus.paddle_y_l, Y_START);
        check("rst_y_r", bus.paddle_y_r, Y_START);
        check("rst_deb", bus.dbg_deb_lvl, 0);
    endtask

    task automatic pix(input int x, input int y, input logic exp, input string tag);
        @(negedge clk);
        #2;
        bus.pixel_x = 10'(x);
        bus.pixel_y = 10'(y);
        #1;
        check(tag, bus.paddle_on, exp);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic saw;
        bus.hold = 0; bus.refr_tick = 0;
        bus.btn_up_l = 0; bus.btn_dn_l = 0; bus.btn_up_r = 0; bus.btn_dn_r = 0;
        bus.pixel_x = 0; bus.pixel_y = 0;

        wait_clks(3);
        rstn = 1'b1;
        @(negedge clk);
        check("init_y_l", bus.paddle_y_l, Y_START);
        check("init_y_r", bus.paddle_y_r, Y_START);
        check("rgb", bus.paddle_rgb, 12'hFFF);
        rand_pix = 1'b0;
        pix(0, 0, 1'b0, "pix_0_0");
        rand_pix = 1'b1;
        wait_ticks(10);
        check("idle_y_l", bus.paddle_y_l, Y_START);
        check("idle_y_r", bus.paddle_y_r, Y_START);

        // Debounce latency, then five moves up on the left.
        bus.btn_up_l = 1'b1;
        wait_clks(5);
        check("deb_lat5", bus.dbg_deb_lvl[0], 1'b0);
        wait_clks(1);
        check("deb_lat6", bus.dbg_deb_lvl[0], 1'b1);
        wait_ticks(5);
        check("up5_y_l", bus.paddle_y_l, 195);
        check("up5_y_r", bus.paddle_y_r, Y_START);

        // Short glitch on the right down button must be filtered.
        bus.btn_dn_r = 1'b1;
        wait_clks(3);
        bus.btn_dn_r = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            saw |= bus.dbg_deb_lvl[3];
        end
        check("glitch_deb", saw, 1'b0);
        wait_ticks(2);
        check("glitch_y_r", bus.paddle_y_r, Y_START);

        // Saturation at both screen edges.
        bus.btn_dn_r = 1'b1;
        wait_ticks(100);
        check("sat_top", bus.paddle_y_l, 0);
        check("sat_bot", bus.paddle_y_r, Y_MAX);
        bus.btn_up_l = 1'b0;
        bus.btn_dn_r = 1'b0;
        wait_deb(0, 1'b0, "rel_up_l");
        wait_deb(3, 1'b0, "rel_dn_r");

        // Both directions held: no motion.
        apply_reset();
        bus.btn_up_l = 1'b1;
        bus.btn_dn_l = 1'b1;
        wait_deb(0, 1'b1, "both_up");
        wait_deb(1, 1'b1, "both_dn");
        wait_ticks(5);
        check("both_y_l", bus.paddle_y_l, Y_START);
        bus.btn_up_l = 1'b0;
        bus.btn_dn_l = 1'b0;
        wait_deb(0, 1'b0, "both_rel_u");
        wait_deb(1, 1'b0, "both_rel_d");

        // Hold freezes movement; releasing it resumes 4 px per tick.
        bus.hold = 1'b1;
        bus.btn_up_r = 1'b1;
        wait_deb(2, 1'b1, "hold_deb");
        wait_ticks(5);
        check("hold_y_r", bus.paddle_y_r, Y_START);
        bus.hold = 1'b0;
        wait_ticks(1);
        check("unhold1", bus.paddle_y_r, 211);
        wait_ticks(1);
        check("unhold2", bus.paddle_y_r, 207);
        bus.btn_up_r = 1'b0;
        wait_deb(2, 1'b0, "unhold_rel");

        // Pixel mask edges with both paddles at the start position.
        apply_reset();
        rand_pix = 1'b0;
        pix(20, 215, 1'b1, "pix_l_tl");
        pix(29, 264, 1'b1, "pix_l_br");
        pix(30, 215, 1'b0, "pix_l_xo");
        pix(19, 215, 1'b0, "pix_l_xb");
        pix(20, 214, 1'b0, "pix_l_ya");
        pix(600, 264, 1'b1, "pix_r_bl");
        pix(600, 265, 1'b0, "pix_r_yb");
        pix(609, 215, 1'b1, "pix_r_tr");
        pix(610, 215, 1'b0, "pix_r_xo");
        rand_pix = 1'b1;

        // Asynchronous reset while moving.
        bus.btn_dn_l = 1'b1;
        wait_deb(1, 1'b1, "mv_deb");
        wait_ticks(3);
        check("mv_y_l", bus.paddle_y_l, 227);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_y_l", bus.paddle_y_l, Y_START);
        check("arst_y_r", bus.paddle_y_r, Y_START);
        check("arst_deb", bus.dbg_deb_lvl, 0);
        bus.btn_dn_l = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Random button and hold traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) bus.btn_up_l = ~bus.btn_up_l;
            if ($urandom_range(0, 15) == 0) bus.btn_dn_l = ~bus.btn_dn_l;
            if ($urandom_range(0, 15) == 0) bus.btn_up_r = ~bus.btn_up_r;
            if ($urandom_range(0, 15) == 0) bus.btn_dn_r = ~bus.btn_dn_r;
            if ($urandom_range(0, 99) == 0) bus.hold = ~bus.hold;
        end
        bus.hold = 1'b0;
        wait_clks(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
